// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/gnt + rvalid data port,
// with registered writeback fields and an upstream stall while an access is in flight.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [4:0]  ALUop_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] StoreData_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  WriteDataNum_i,
    input  logic        WriteReg_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        WriteReg_o,
    output logic [4:0]  WriteDataNum_o,
    output logic [31:0] WriteData_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]     OP_LW    = 5'b10100;
    localparam logic [4:0]     OP_SW    = 5'b10101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [31:0]      dmem_addr_q, dmem_addr_d;
    logic [31:0]      dmem_wdata_q, dmem_wdata_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wreg_q, wreg_d;
    logic [4:0]       wnum_q, wnum_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             misalign_q, misalign_d;
    logic             timeout_q, timeout_d;
    logic             is_load_q, is_load_d;
    logic             wreg_en_q, wreg_en_d;

    logic is_mem_op;
    logic addr_misaligned;
    logic at_limit;
    logic accept;

    assign is_mem_op       = (ALUop_i == OP_LW) || (ALUop_i == OP_SW);
    assign addr_misaligned = (MemAddr_i[1:0] != 2'b00);
    assign accept          = (state_q == ST_IDLE) && ex_valid_i;
    // The counter holds cycles already spent in the state, so this is the final allowed cycle.
    assign at_limit        = (tmo_cnt_q == CNT_LAST);

    assign stall_o = (state_q != ST_IDLE) || (ex_valid_i && is_mem_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i && is_mem_op && !addr_misaligned) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    state_d = (!is_load_q || dmem_rvalid_i) ? ST_DONE : ST_WAIT;
                end else if (at_limit) begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid_i || at_limit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmo_cnt_d    = tmo_cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wreg_d       = 1'b0;
        wnum_d       = wnum_q;
        wdata_d      = wdata_q;
        misalign_d   = 1'b0;
        timeout_d    = 1'b0;
        is_load_d    = is_load_q;
        wreg_en_d    = wreg_en_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wnum_d    = WriteDataNum_i;
                    wreg_en_d = WriteReg_i && (WriteDataNum_i != 5'd0);
                    is_load_d = (ALUop_i == OP_LW);
                    if (!is_mem_op) begin
                        wb_valid_d = 1'b1;
                        wreg_d     = WriteReg_i && (WriteDataNum_i != 5'd0);
                        wdata_d    = WriteData_i;
                    end else if (addr_misaligned) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        wdata_d    = 32'd0;
                    end else begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = (ALUop_i == OP_SW);
                        dmem_addr_d  = {MemAddr_i[31:2], 2'b00};
                        dmem_wdata_d = (ALUop_i == OP_SW) ? StoreData_i : 32'd0;
                        tmo_cnt_d    = '0;
                    end
                end
            end
            ST_REQ: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (dmem_gnt_i) begin
                    dmem_req_d = 1'b0;
                    if (!is_load_q) begin
                        wb_valid_d = 1'b1;
                        wdata_d    = 32'd0;
                    end else if (dmem_rvalid_i) begin
                        wb_valid_d = 1'b1;
                        wreg_d     = wreg_en_q;
                        wdata_d    = dmem_rdata_i;
                    end else begin
                        tmo_cnt_d = '0;
                    end
                end else if (at_limit) begin
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    wdata_d    = 32'd0;
                end
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (dmem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wreg_d     = wreg_en_q;
                    wdata_d    = dmem_rdata_i;
                end else if (at_limit) begin
                    wb_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    wdata_d    = 32'd0;
                end
            end
            default: begin
            end
        endcase
    end

    // Every externally visible register clears on reset so a mid-flight access is abandoned cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q    <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            wb_valid_q   <= 1'b0;
            wreg_q       <= 1'b0;
            wnum_q       <= 5'd0;
            wdata_q      <= 32'd0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            tmo_cnt_q    <= tmo_cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wreg_q       <= wreg_d;
            wnum_q       <= wnum_d;
            wdata_q      <= wdata_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
        end
    end

    // Per-transaction attributes are only consumed after a fresh capture, so they need no reset.
    always_ff @(posedge clk) begin
        is_load_q <= is_load_d;
        wreg_en_q <= wreg_en_d;
    end

    assign dmem_req_o     = dmem_req_q;
    assign dmem_we_o      = dmem_we_q;
    assign dmem_addr_o    = dmem_addr_q;
    assign dmem_wdata_o   = dmem_wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign WriteReg_o     = wreg_q;
    assign WriteDataNum_o = wnum_q;
    assign WriteData_o    = wdata_q;
    assign misalign_o     = misalign_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops, each compared against a
// transaction-level model that predicts writeback timing and contents from the handshake plan.
module tb_mem_access_stage;

    localparam int TMO = 4;
    localparam logic [4:0] OP_LW = 5'b10100;
    localparam logic [4:0] OP_SW = 5'b10101;
    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  ALUop_i;
    logic [31:0] MemAddr_i;
    logic [31:0] StoreData_i;
    logic [31:0] WriteData_i;
    logic [4:0]  WriteDataNum_i;
    logic        WriteReg_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        WriteReg_o;
    logic [4:0]  WriteDataNum_o;
    logic [31:0] WriteData_o;
    logic        misalign_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid_i),
        .ALUop_i        (ALUop_i),
        .MemAddr_i      (MemAddr_i),
        .StoreData_i    (StoreData_i),
        .WriteData_i    (WriteData_i),
        .WriteDataNum_i (WriteDataNum_i),
        .WriteReg_i     (WriteReg_i),
        .stall_o        (stall_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .WriteReg_o     (WriteReg_o),
        .WriteDataNum_o (WriteDataNum_o),
        .WriteData_o    (WriteData_o),
        .misalign_o     (misalign_o),
        .timeout_o      (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // gc: request cycle (1-based) on which gnt is given; k: cycles after gnt until rvalid (0 = same cycle).
    task automatic run_op(input int kind, input logic [4:0] alu, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] wdata, input logic [4:0] num,
                          input logic wr, input int gc, input int k, input logic [31:0] rd);
        logic mem, mis, tmo_exp, qual, exp_wr, seen;
        logic [31:0] exp_data;
        int wb_at, req_last;

        mem      = (kind != K_ALU);
        mis      = mem && (addr[1:0] != 2'b00);
        qual     = wr && (num != 5'd0);
        tmo_exp  = 1'b0;
        exp_wr   = 1'b0;
        exp_data = 32'd0;
        req_last = 0;
        seen     = 1'b0;
        if (!mem) begin
            wb_at = 1; exp_wr = qual; exp_data = wdata;
        end else if (mis) begin
            wb_at = 1;
        end else if (gc > TMO) begin
            wb_at = TMO + 1; tmo_exp = 1'b1; req_last = TMO;
        end else begin
            req_last = gc;
            if (kind == K_SW) begin
                wb_at = gc + 1;
            end else if (k <= TMO) begin
                wb_at = gc + k + 1; exp_wr = qual; exp_data = rd;
            end else begin
                wb_at = gc + TMO + 1; tmo_exp = 1'b1;
            end
        end

        @(negedge clk);
        ex_valid_i     = 1'b1;
        ALUop_i        = (kind == K_LW) ? OP_LW : (kind == K_SW) ? OP_SW : alu;
        MemAddr_i      = addr;
        StoreData_i    = sdata;
        WriteData_i    = wdata;
        WriteDataNum_i = num;
        WriteReg_i     = wr;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'($urandom_range(0, 1));
        dmem_rdata_i   = $urandom;
        #1;
        chk("stall_accept", 32'(stall_o), 32'(mem));
        @(posedge clk);
        #1;
        ex_valid_i    = 1'b0;
        dmem_rvalid_i = 1'b0;

        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            chk("wb_valid", 32'(wb_valid_o), 32'(t == wb_at));
            chk("dmem_req", 32'(dmem_req_o), 32'(mem && !mis && t <= req_last));
            chk("stall", 32'(stall_o), 32'(mem && !mis && t <= wb_at));
            chk("misalign", 32'(misalign_o), 32'(t == wb_at && mis));
            chk("timeout", 32'(timeout_o), 32'(t == wb_at && tmo_exp));
            if (dmem_req_o) begin
                chk("dmem_addr", dmem_addr_o, addr);
                chk("dmem_we", 32'(dmem_we_o), 32'(kind == K_SW));
                if (kind == K_SW) chk("dmem_wdata", dmem_wdata_o, sdata);
            end
            if (t == wb_at) begin
                seen = 1'b1;
                chk("WriteReg", 32'(WriteReg_o), 32'(exp_wr));
                chk("WriteDataNum", 32'(WriteDataNum_o), 32'(num));
                if (!mis && !tmo_exp) chk("WriteData", WriteData_o, exp_data);
                break;
            end
            dmem_gnt_i    = (t == gc);
            dmem_rvalid_i = (kind == K_LW && t == gc + k) || (t < gc && $urandom_range(0, 2) == 0);
            dmem_rdata_i  = (kind == K_LW && t == gc + k) ? rd : $urandom;
            ex_valid_i    = 1'($urandom_range(0, 1));
            ALUop_i       = 5'($urandom);
            MemAddr_i     = $urandom;
            WriteData_i   = $urandom;
        end
        chk("wb_seen", 32'(seen), 32'd1);
        ex_valid_i    = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        int kind, gc, k;
        logic [4:0] alu;
        logic [31:0] addr;

        rst = 1'b1;
        ex_valid_i = 1'b0; ALUop_i = 5'd0; MemAddr_i = 32'd0; StoreData_i = 32'd0;
        WriteData_i = 32'd0; WriteDataNum_i = 5'd0; WriteReg_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_WriteReg", 32'(WriteReg_o), 32'd0);
        chk("rst_WriteDataNum", 32'(WriteDataNum_o), 32'd0);
        chk("rst_WriteData", WriteData_o, 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        rst = 1'b0;

        run_op(K_ALU, 5'b00001, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1, 1, 0, 32'h0);
        run_op(K_ALU, 5'b00001, 32'h0, 32'h0, 32'h77, 5'd0, 1'b1, 1, 0, 32'h0);
        run_op(K_LW, 5'd0, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 2, 3, 32'hDEADBEEF);
        run_op(K_SW, 5'd0, 32'h104, 32'hA5A5A5A5, 32'h0, 5'd9, 1'b1, 1, 0, 32'h0);
        run_op(K_LW, 5'd0, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 1, 0, 32'h0);
        run_op(K_LW, 5'd0, 32'h200, 32'h0, 32'h0, 5'd6, 1'b1, 1, 5, 32'h11111111);
        run_op(K_LW, 5'd0, 32'h204, 32'h0, 32'h0, 5'd6, 1'b1, 1, 4, 32'h22222222);
        run_op(K_LW, 5'd0, 32'h208, 32'h0, 32'h0, 5'd8, 1'b1, 3, 0, 32'h33333333);
        run_op(K_SW, 5'd0, 32'h20C, 32'h12345678, 32'h0, 5'd1, 1'b1, TMO, 0, 32'h0);
        run_op(K_SW, 5'd0, 32'h210, 32'h12345678, 32'h0, 5'd1, 1'b1, TMO + 1, 0, 32'h0);

        // Reset while a load waits for data; the late rvalid must be dropped.
        @(negedge clk);
        ex_valid_i = 1'b1; ALUop_i = OP_LW; MemAddr_i = 32'h300;
        WriteDataNum_i = 5'd5; WriteReg_i = 1'b1;
        @(negedge clk);
        ex_valid_i = 1'b0; dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        chk("rstw_req_after_gnt", 32'(dmem_req_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_stall", 32'(stall_o), 32'd0);
        chk("rstw_req", 32'(dmem_req_o), 32'd0);
        chk("rstw_wb", 32'(wb_valid_o), 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBADBAD00;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk("rstw_late_wb", 32'(wb_valid_o), 32'd0);
        chk("rstw_late_req", 32'(dmem_req_o), 32'd0);
        @(negedge clk);
        chk("rstw_late_wb2", 32'(wb_valid_o), 32'd0);
        run_op(K_ALU, 5'b00010, 32'h0, 32'h0, 32'hCAFE0001, 5'd12, 1'b1, 1, 0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            alu  = 5'($urandom);
            if (alu == OP_LW || alu == OP_SW) alu = 5'd0;
            addr = $urandom;
            if (kind != K_ALU && $urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            gc = $urandom_range(1, TMO + 2);
            k  = $urandom_range(0, TMO + 2);
            run_op(kind, alu, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   gc, k, $urandom);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
